// File: rtl/risc_controller.sv
// VeriRISC instruction sequencer.
// Walks an 8-phase cycle per instruction and decodes the IR opcode into the
// datapath control strobes (address mux, memory read/write, IR/PC/AC loads,
// PC increment, data-bus enable and halt).
module risc_controller #(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       halt,
  output logic       ld_pc,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr
);

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;

  state_t state;

  logic alu_op;
  logic is_hlt;
  logic is_skz;
  logic is_sto;
  logic is_jmp;

  assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);
  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);

  // Phase sequencer: one phase per clock, HLT optionally parks the FSM, and
  // any unused encoding falls back to the start of an instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INST_ADDR;
    end else begin
      case (state)
        INST_ADDR:  state <= INST_FETCH;
        INST_FETCH: state <= INST_LOAD;
        INST_LOAD:  state <= IDLE;
        IDLE:       state <= OP_ADDR;
        OP_ADDR:    state <= (HALT_STICKY && is_hlt) ? HALTED : OP_FETCH;
        OP_FETCH:   state <= ALU_OP;
        ALU_OP:     state <= STORE;
        STORE:      state <= INST_ADDR;
        HALTED:     state <= HALTED;
        default:    state <= INST_ADDR;
      endcase
    end
  end

  // Control decode from the current phase, qualified by opcode and the zero
  // flag; outputs must follow the phase immediately, including during reset.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    case (state)
      INST_ADDR: begin
        sel = 1'b1;
      end
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = is_hlt;
      end
      OP_FETCH: begin
        rd = alu_op;
      end
      ALU_OP: begin
        rd     = alu_op;
        inc_pc = is_skz && zero;
        ld_pc  = is_jmp;
        data_e = is_sto;
      end
      STORE: begin
        rd     = alu_op;
        ld_ac  = alu_op;
        ld_pc  = is_jmp;
        wr     = is_sto;
        data_e = is_sto;
      end
      HALTED: begin
        halt = 1'b1;
      end
      default: begin
        sel = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_risc_controller.sv
// Self-checking bench for risc_controller.
// Two instances run side by side from the same stimulus, one parking on HLT
// and one pulsing halt, each checked against its own phase model.
module tb_risc_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] opcode;
  logic       zero;

  logic sel_s, rd_s, ld_ir_s, inc_pc_s, halt_s, ld_pc_s, data_e_s, ld_ac_s, wr_s;
  logic sel_n, rd_n, ld_ir_n, inc_pc_n, halt_n, ld_pc_n, data_e_n, ld_ac_n, wr_n;
  logic [8:0] out_s;
  logic [8:0] out_n;

  // Output vector order: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr
  assign out_s = {sel_s, rd_s, ld_ir_s, inc_pc_s, halt_s, ld_pc_s, data_e_s, ld_ac_s, wr_s};
  assign out_n = {sel_n, rd_n, ld_ir_n, inc_pc_n, halt_n, ld_pc_n, data_e_n, ld_ac_n, wr_n};

  risc_controller #(.HALT_STICKY(1'b1)) dut_sticky (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .sel(sel_s), .rd(rd_s), .ld_ir(ld_ir_s), .inc_pc(inc_pc_s), .halt(halt_s),
    .ld_pc(ld_pc_s), .data_e(data_e_s), .ld_ac(ld_ac_s), .wr(wr_s)
  );

  risc_controller #(.HALT_STICKY(1'b0)) dut_pulse (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .sel(sel_n), .rd(rd_n), .ld_ir(ld_ir_n), .inc_pc(inc_pc_n), .halt(halt_n),
    .ld_pc(ld_pc_n), .data_e(data_e_n), .ld_ac(ld_ac_n), .wr(wr_n)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [8:0] exp_s;
    logic [8:0] exp_n;
  } sb_entry_t;

  sb_entry_t sb[$];

  int checks = 0;
  int errors = 0;
  int ph_s   = 0;
  int ph_n   = 0;

  localparam logic [8:0] RESET_OUT = 9'b1_0000_0000;

  task automatic checkOutput(input string tag, input logic [8:0] actual, input logic [8:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %b expected %b (sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr)",
               tag, actual, expected);
    end
  endtask

  // Expected outputs per phase (8 = halted), written from the control table
  function automatic logic [8:0] expOut(input int ph, input logic [2:0] op, input logic z);
    logic aluop;
    logic e_sel, e_rd, e_ld_ir, e_inc, e_halt, e_ld_pc, e_de, e_ld_ac, e_wr;
    aluop   = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    e_sel   = (ph <= 3);
    e_rd    = (ph >= 1 && ph <= 3) || ((ph >= 5 && ph <= 7) && aluop);
    e_ld_ir = (ph == 2) || (ph == 3);
    e_inc   = (ph == 4) || (ph == 6 && op == 3'd1 && z);
    e_halt  = (ph == 4 && op == 3'd0) || (ph == 8);
    e_ld_pc = (ph == 6 || ph == 7) && (op == 3'd7);
    e_de    = (ph == 6 || ph == 7) && (op == 3'd6);
    e_ld_ac = (ph == 7) && aluop;
    e_wr    = (ph == 7) && (op == 3'd6);
    return {e_sel, e_rd, e_ld_ir, e_inc, e_halt, e_ld_pc, e_de, e_ld_ac, e_wr};
  endfunction

  function automatic int nextPh(input int ph, input logic [2:0] op, input bit sticky);
    if (ph == 8) return 8;
    if (ph == 4 && op == 3'd0 && sticky) return 8;
    return (ph + 1) % 8;
  endfunction

  // One clock of stimulus: called at posedge+1, returns at the next posedge+1
  task automatic applyStimulus(input logic [2:0] op, input logic z);
    sb_entry_t e;
    opcode = op;
    zero   = z;
    e.tag   = $sformatf("op%0d z%0d ph_s%0d ph_n%0d", op, z, ph_s, ph_n);
    e.exp_s = expOut(ph_s, op, z);
    e.exp_n = expOut(ph_n, op, z);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    checkOutput({"sticky ", e.tag}, out_s, e.exp_s);
    checkOutput({"pulse ", e.tag}, out_n, e.exp_n);
    @(posedge clk);
    #1;
    ph_s = nextPh(ph_s, op, 1'b1);
    ph_n = nextPh(ph_n, op, 1'b0);
  endtask

  // Eight phases of one instruction; opcode is junk before IDLE, zero is junk outside ALU_OP
  task automatic runInstr(input logic [2:0] op, input logic z);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] o;
      logic       zz;
      o  = (ph_n <= 2) ? 3'($urandom_range(7)) : op;
      zz = (ph_n == 6) ? z : 1'($urandom_range(1));
      applyStimulus(o, zz);
    end
  endtask

  // Asynchronous reset: checked immediately and across three clocks, released at posedge+1
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    ph_s = 0;
    ph_n = 0;
    checkOutput("reset immediate sticky", out_s, RESET_OUT);
    checkOutput("reset immediate pulse", out_n, RESET_OUT);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("reset hold%0d sticky", i), out_s, RESET_OUT);
      checkOutput($sformatf("reset hold%0d pulse", i), out_n, RESET_OUT);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Main sequence: each opcode class, mid-instruction reset, then HLT
  initial begin
    rst_n  = 1'b1;
    opcode = 3'd0;
    zero   = 1'b0;
    #2;
    doReset();

    runInstr(3'd2, 1'b0);
    runInstr(3'd6, 1'b0);
    runInstr(3'd1, 1'b1);
    runInstr(3'd1, 1'b0);
    runInstr(3'd7, 1'b0);
    runInstr(3'd3, 1'b1);
    runInstr(3'd4, 1'b0);
    runInstr(3'd5, 1'b1);

    for (int i = 0; i < 5; i++) applyStimulus((i <= 2) ? 3'd5 : 3'd2, 1'b0);
    #2;
    doReset();
    runInstr(3'd2, 1'b0);

    runInstr(3'd0, 1'b0);
    for (int i = 0; i < 3; i++) runInstr(3'd2, 1'b1);
    doReset();
    runInstr(3'd7, 1'b1);
    runInstr(3'd6, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout got running expected finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
